mips_pipeline_mem_access: RTL
=============================

// Module: mips_pipeline_mem_access
// PURPOSE
//  MEM-stage consumer of the ExMem pipeline bundle. It retires ALU ops and runs
//  loads/stores against the data memory over a valid/ready request/response
//  handshake. It stalls upstream while an access is outstanding and emits the
//  registered MemWb bundle to the WB stage.
// PARAMETERS
//  ADDR_W   32  data-memory byte-address width (low bits of aluResult)
//  WORD_W   32  datapath word width; only 32 is supported
// PORTS
//  clock          in   1   single clock, rising edge
//  reset          in   1   asynchronous, active-high
//  pipeValid      in   1   ExMem bundle holds a live instruction
//  aluResult      in   32  ALU result / effective address
//  storeData      in   32  rt value for stores
//  memRead        in   1   load
//  memWrite       in   1   store
//  memSize        in   2   0=byte 1=half 2=word (3 reserved = word)
//  memSigned      in   1   sign-extend loads
//  regWrite       in   1   instruction writes a register
//  writeReg       in   5   destination register
//  flush          in   1   kill current ExMem instruction
//  stall          out  1   hold ExMem register and all earlier stages
//  dmemReqValid   out  1   request valid
//  dmemReqReady   in   1   memory accepts request
//  dmemReqWrite   out  1   1=store 0=load
//  dmemReqAddr    out  32  word-aligned address {aluResult[31:2],2'b00}
//  dmemReqWdata   out  32  lane-steered store data
//  dmemReqBe      out  4   byte enables, bit i = byte lane i
//  dmemRespValid  in   1   load data valid
//  dmemRespRdata  in   32  raw loaded word
//  addrError      out  1   one-cycle pulse: misaligned access dropped
//  wbValid, wbRegWrite, wbWriteReg[5], wbData[32]  out  registered MemWb bundle
// BEHAVIOUR
//  Reset: FSM=IDLE; stall, dmemReqValid, addrError, wb* all 0.
//  Little-endian lanes. Byte BE=1<<a[1:0]; half BE=4'b0011<<{a[1],1'b0}; word 4'hF.
//  Store data replicated per lane (byte x4, half x2). Loads extract from the same
//   lane, then zero-/sign-extend per memSigned.
//  Misaligned: half with a[0]=1, word with a[1:0]!=0. No request is issued;
//   addrError pulses; wbValid=1 with wbRegWrite=0; retires in 1 cycle.
//  Non-memory op: wbData=aluResult at the next edge; stall=0 (latency 1).
//  FSM (memop = pipeValid & (memRead|memWrite) & aligned & !flush):
//   IDLE: dmemReqValid=memop (combinational). Accepted and store -> retire at
//         this edge, stay IDLE. Accepted and load -> RESP. Not accepted -> REQ.
//   REQ:  dmemReqValid=1 with fields held stable; on accept: store -> IDLE
//         (retire), load -> RESP.
//   RESP: wait dmemRespValid; on valid capture extracted data -> IDLE (retire).
//  stall = memop-in-IDLE & !(store & ready) | REQ & !(store & ready) | RESP & !respValid.
//  Upstream holds the bundle stable while stall=1; request fields derive from it.
//  Retire: wb* load from the bundle/data at that edge; otherwise wbValid=0 next cycle.
//  flush: in IDLE the instruction is dropped (wbValid=0). In REQ before accept:
//   dmemReqValid drops, go IDLE, no retire. In REQ with accept in the same cycle,
//   or in RESP: the access completes, a load response is consumed and discarded,
//   and wbValid=0.
//  A response received outside RESP is a protocol error and is ignored.
//  reset mid-access: FSM to IDLE immediately; the memory side must also be reset.
// STRUCTURE
//  Header Mips/Pipeline/MemWb/Pipeline.v: MemWb bundle type/pack macros.
//  Header Mips/Datapath/Memory/Size.v: memSize encodings BYTE/HALF/WORD.
//  FSM state encodings stay local to this module.
//  Sub-module mips_datapath_mem_lane: combinational BE generation, store
//   replication, load extraction/extension, alignment check.
// TESTING
//  Non-mem op aluResult=0x1234 -> next cycle wbValid=1, wbData=0x1234, stall never 1.
//  sw 0xDEADBEEF @0x100, ready=1 -> Be=4'hF, Addr=0x100, 1-cycle retire, no stall.
//  sb 0x000000AB @0x103, ready low 2 cycles -> Be=4'b1000, Wdata=0xABABABAB held; stall 2 cycles.
//  lb signed @0x102, rdata=0x0080FF00 after 3 cycles -> wbData=0xFFFFFF80; lhu @0x102 -> 0x00000080.
//  lw @0x101 -> no dmemReqValid, addrError pulse, wbRegWrite=0.
//  Load with flush in RESP -> response consumed, wbValid=0, FSM IDLE; reset in REQ -> all outputs 0.

Source files
------------

// File: rtl/mips_pipeline_mem_access_pkg.sv
// Shared MEM-stage types: memory access size encodings and the MemWb bundle
// handed to the write-back stage.
package mips_pipeline_mem_access_pkg;

   typedef enum logic [1:0] {
      MemByte = 2'd0,
      MemHalf = 2'd1,
      MemWord = 2'd2,
      MemRsvd = 2'd3
   } mem_size_e;

   typedef struct packed {
      logic        valid;
      logic        reg_write;
      logic [4:0]  write_reg;
      logic [31:0] data;
   } memwb_t;

   localparam memwb_t MemWbIdle = '{valid: 1'b0, reg_write: 1'b0, write_reg: 5'd0, data: 32'd0};

   function automatic memwb_t memwb_pack(input logic        reg_write,
                                         input logic [4:0]  write_reg,
                                         input logic [31:0] data);
      memwb_pack = '{valid: 1'b1, reg_write: reg_write, write_reg: write_reg, data: data};
   endfunction

endpackage

// File: rtl/mips_datapath_mem_lane.sv
// Little-endian byte-lane logic for data-memory accesses: byte enables, store
// replication, load lane extraction with zero/sign extension, alignment check.
module mips_datapath_mem_lane
   import mips_pipeline_mem_access_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] store_data,
   input  logic [31:0] load_word,
   output logic        aligned,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   logic [15:0] lane_half;

   // Addressed lane moved to bit 0; half offsets are only used when aligned.
   assign lane_half = 16'(load_word >> {addr_lo, 3'b000});

   always_comb begin
      aligned   = 1'b1;
      be        = 4'hF;
      wdata     = store_data;
      load_data = load_word;
      unique case (mem_size_e'(size))
         MemByte: begin
            be        = 4'b0001 << addr_lo;
            wdata     = {4{store_data[7:0]}};
            load_data = {{24{sign_ext & lane_half[7]}}, lane_half[7:0]};
         end
         MemHalf: begin
            aligned   = ~addr_lo[0];
            be        = 4'b0011 << {addr_lo[1], 1'b0};
            wdata     = {2{store_data[15:0]}};
            load_data = {{16{sign_ext & lane_half[15]}}, lane_half};
         end
         default: aligned = (addr_lo == 2'b00);
      endcase
   end

endmodule

// File: rtl/mips_pipeline_mem_access.sv
// MEM stage: retires ALU ops, runs loads/stores over a valid/ready data-memory
// handshake, stalls upstream while an access is outstanding, registers MemWb.
module mips_pipeline_mem_access
   import mips_pipeline_mem_access_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned WORD_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              pipeValid,
   input  logic [WORD_W-1:0] aluResult,
   input  logic [WORD_W-1:0] storeData,
   input  logic              memRead,
   input  logic              memWrite,
   input  logic [1:0]        memSize,
   input  logic              memSigned,
   input  logic              regWrite,
   input  logic [4:0]        writeReg,
   input  logic              flush,
   output logic              stall,
   output logic              dmemReqValid,
   input  logic              dmemReqReady,
   output logic              dmemReqWrite,
   output logic [ADDR_W-1:0] dmemReqAddr,
   output logic [WORD_W-1:0] dmemReqWdata,
   output logic [3:0]        dmemReqBe,
   input  logic              dmemRespValid,
   input  logic [WORD_W-1:0] dmemRespRdata,
   output logic              addrError,
   output logic              wbValid,
   output logic              wbRegWrite,
   output logic [4:0]        wbWriteReg,
   output logic [WORD_W-1:0] wbData
);

   typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

   state_e      state_q;
   memwb_t      memwb_q;
   logic [1:0]  resp_addr_q;
   logic [1:0]  resp_size_q;
   logic        resp_signed_q;
   logic        resp_reg_write_q;
   logic [4:0]  resp_write_reg_q;
   logic        resp_killed_q;

   logic        in_idle, in_req, in_resp;
   logic        is_mem, memop, store_done;
   logic [1:0]  lane_addr, lane_size;
   logic        lane_signed;
   logic        aligned;
   logic [3:0]  lane_be;
   logic [31:0] lane_wdata, load_data;

   assign in_idle = (state_q == StIdle);
   assign in_req  = (state_q == StReq);
   assign in_resp = (state_q == StResp);

   // While waiting for a response the bundle may be killed, so lane selection
   // comes from the copy captured at request time.
   assign lane_addr   = in_resp ? resp_addr_q   : aluResult[1:0];
   assign lane_size   = in_resp ? resp_size_q   : memSize;
   assign lane_signed = in_resp ? resp_signed_q : memSigned;

   mips_datapath_mem_lane u_lane (
      .addr_lo    (lane_addr),
      .size       (lane_size),
      .sign_ext   (lane_signed),
      .store_data (storeData),
      .load_word  (dmemRespRdata),
      .aligned    (aligned),
      .be         (lane_be),
      .wdata      (lane_wdata),
      .load_data  (load_data)
   );

   assign is_mem     = memRead | memWrite;
   assign memop      = pipeValid & is_mem & aligned & ~flush;
   assign store_done = memWrite & dmemReqReady;

   // A flush withdraws a pending request unless the memory takes it this cycle.
   assign dmemReqValid = (in_idle & memop) | (in_req & (~flush | dmemReqReady));
   assign dmemReqWrite = memWrite;
   assign dmemReqAddr  = {aluResult[ADDR_W-1:2], 2'b00};
   assign dmemReqWdata = lane_wdata;
   assign dmemReqBe    = lane_be;

   assign stall = (in_idle & memop & ~store_done) | (in_req & ~store_done) |
                  (in_resp & ~dmemRespValid);

   assign wbValid    = memwb_q.valid;
   assign wbRegWrite = memwb_q.reg_write;
   assign wbWriteReg = memwb_q.write_reg;
   assign wbData     = memwb_q.data;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q          <= StIdle;
         memwb_q          <= MemWbIdle;
         addrError        <= 1'b0;
         resp_addr_q      <= 2'b00;
         resp_size_q      <= 2'b00;
         resp_signed_q    <= 1'b0;
         resp_reg_write_q <= 1'b0;
         resp_write_reg_q <= 5'd0;
         resp_killed_q    <= 1'b0;
      end else begin
         memwb_q.valid <= 1'b0;
         addrError     <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (pipeValid && !flush) begin
                  if (!is_mem) begin
                     memwb_q <= memwb_pack(regWrite, writeReg, aluResult);
                  end else if (!aligned) begin
                     memwb_q   <= memwb_pack(1'b0, writeReg, aluResult);
                     addrError <= 1'b1;
                  end else if (memWrite) begin
                     if (dmemReqReady) begin
                        memwb_q <= memwb_pack(regWrite, writeReg, aluResult);
                     end else begin
                        state_q <= StReq;
                     end
                  end else begin
                     resp_addr_q      <= aluResult[1:0];
                     resp_size_q      <= memSize;
                     resp_signed_q    <= memSigned;
                     resp_reg_write_q <= regWrite;
                     resp_write_reg_q <= writeReg;
                     resp_killed_q    <= 1'b0;
                     state_q          <= dmemReqReady ? StResp : StReq;
                  end
               end
            end
            StReq: begin
               if (dmemReqReady) begin
                  if (memWrite) begin
                     if (!flush) memwb_q <= memwb_pack(regWrite, writeReg, aluResult);
                     state_q <= StIdle;
                  end else begin
                     resp_killed_q <= flush;
                     state_q       <= StResp;
                  end
               end else if (flush) begin
                  state_q <= StIdle;
               end
            end
            StResp: begin
               if (flush) resp_killed_q <= 1'b1;
               if (dmemRespValid) begin
                  if (!resp_killed_q && !flush) begin
                     memwb_q <= memwb_pack(resp_reg_write_q, resp_write_reg_q, load_data);
                  end
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
